// File: rtl/mcb_resp_pkg.sv
// Shared encodings, FSM state type and FIFO depths for the MCB port responder.
// Instruction decode helper maps the 3-bit MCB instruction onto an internal op.
package mcb_resp_pkg;

  localparam logic [2:0] INSTR_WR    = 3'b000;
  localparam logic [2:0] INSTR_RD    = 3'b001;
  localparam logic [2:0] INSTR_WR_AP = 3'b010;
  localparam logic [2:0] INSTR_RD_AP = 3'b011;

  localparam int CMD_DEPTH = 4;
  localparam int WR_DEPTH  = 64;
  localparam int RD_DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_WR  = 2'd0,
    OP_RD  = 2'd1,
    OP_NOP = 2'd2
  } op_e;

  // Auto-precharge variants behave like plain reads/writes; 1xx is a refresh no-op.
  function automatic op_e decode_instr(input logic [2:0] instr);
    op_e op;
    case (instr)
      INSTR_WR, INSTR_WR_AP: op = OP_WR;
      INSTR_RD, INSTR_RD_AP: op = OP_RD;
      default:               op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mcb_resp_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty/count.
// DEPTH must be a power of two; dout reads 0 while empty.
module mcb_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [CW-1:0]    count_n_s;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;

  // Occupancy after this cycle's accepted push/pop
  always_comb begin
    count_n_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_n_s = count_r + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_n_s = count_r - CW'(1);
    end else begin
      count_n_s = count_r;
    end
  end

  // Pointers, count and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_n_s;
      full_r  <= (count_n_s == CW'(DEPTH));
      empty_r <= (count_n_s == CW'(0));
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = empty_r ? '0 : mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/mcb_port_responder.sv
// MCB user-port responder backed by on-chip 64-bit word memory instead of DDR.
// Define MCB_RESP_MASK_EN to honour wr_mask per byte; otherwise all bytes are written.
module mcb_port_responder
  import mcb_resp_pkg::*;
#(
  parameter int MEM_AW       = 10,
  parameter int READ_LAT     = 4,
  parameter int CALIB_CYCLES = 16
) (
  input  logic        c3_clk0,
  input  logic        c3_sys_rst_n,
  output logic        calib_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_byte_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [7:0]  wr_mask,
  input  logic [63:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [63:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);

  localparam int CMD_W = 8 + MEM_AW;
  localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
  localparam int LAT_W = $clog2(READ_LAT + 1);

  logic [CAL_W-1:0]         calib_cnt_r;
  logic                     calib_done_r;
  logic [CMD_W-1:0]         cmd_din_s;
  logic [CMD_W-1:0]         cmd_dout_s;
  logic [$clog2(CMD_DEPTH):0] cmd_count_unused_s;
  logic                     addr_unused_s;
  op_e                      cmd_op_s;
  logic [5:0]               cmd_bl_s;
  logic [MEM_AW-1:0]        cmd_addr_s;
  logic                     cmd_pop_s;
  state_e                   state_r, state_n;
  op_e                      op_r, op_n;
  logic [MEM_AW-1:0]        addr_r, addr_n;
  logic [6:0]               remain_r, remain_n;
  logic [LAT_W-1:0]         drain_r, drain_n;
  logic                     wr_issue_s;
  logic                     rd_issue_s;
  logic [63:0]              wr_word_s;
  logic [7:0]               wr_bmask_s;
  logic [7:0]               wr_head_mask_s;
  logic [63:0]              last_data_r;
  logic [7:0]               last_mask_r;
  logic [63:0]              mem_r [2**MEM_AW];
  logic [63:0]              pipe_data_r [READ_LAT];
  logic [READ_LAT-1:0]      pipe_vld_r;
  logic                     rd_push_s;
  logic                     wr_underrun_r, wr_error_r, rd_overflow_r, rd_error_r;

`ifdef MCB_RESP_MASK_EN
  localparam int WR_W = 72;
  logic [WR_W-1:0] wr_din_s;
  logic [WR_W-1:0] wr_dout_s;
  assign wr_din_s       = {wr_mask, wr_data};
  assign wr_head_mask_s = wr_dout_s[71:64];
`else
  localparam int WR_W = 64;
  logic [WR_W-1:0] wr_din_s;
  logic [WR_W-1:0] wr_dout_s;
  logic            mask_unused_s;
  assign wr_din_s       = wr_data;
  assign wr_head_mask_s = 8'h00;
  assign mask_unused_s  = ^wr_mask;
`endif

  // Calibration counter: calib_done rises CALIB_CYCLES edges after reset release
  always_ff @(posedge c3_clk0) begin
    if (!c3_sys_rst_n) begin
      calib_cnt_r  <= '0;
      calib_done_r <= 1'b0;
    end else if (!calib_done_r) begin
      calib_cnt_r <= calib_cnt_r + CAL_W'(1);
      if (calib_cnt_r == CAL_W'(CALIB_CYCLES - 1)) calib_done_r <= 1'b1;
    end
  end

  assign cmd_din_s     = {decode_instr(cmd_instr), cmd_bl, cmd_byte_addr[MEM_AW+2:3]};
  assign addr_unused_s = ^{cmd_byte_addr[29:MEM_AW+3], cmd_byte_addr[2:0]};
  assign cmd_op_s      = op_e'(cmd_dout_s[CMD_W-1 -: 2]);
  assign cmd_bl_s      = cmd_dout_s[MEM_AW +: 6];
  assign cmd_addr_s    = cmd_dout_s[MEM_AW-1:0];

  mcb_resp_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(c3_clk0), .rst_n(c3_sys_rst_n),
    .push(cmd_en && calib_done_r), .pop(cmd_pop_s),
    .din(cmd_din_s), .dout(cmd_dout_s),
    .full(cmd_full), .empty(cmd_empty), .count(cmd_count_unused_s)
  );

  mcb_resp_fifo #(.WIDTH(WR_W), .DEPTH(WR_DEPTH)) u_wr_fifo (
    .clk(c3_clk0), .rst_n(c3_sys_rst_n),
    .push(wr_en && calib_done_r), .pop(wr_issue_s),
    .din(wr_din_s), .dout(wr_dout_s),
    .full(wr_full), .empty(wr_empty), .count(wr_count)
  );

  mcb_resp_fifo #(.WIDTH(64), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk(c3_clk0), .rst_n(c3_sys_rst_n),
    .push(rd_push_s), .pop(rd_en && calib_done_r),
    .din(pipe_data_r[READ_LAT-1]), .dout(rd_data),
    .full(rd_full), .empty(rd_empty), .count(rd_count)
  );

  // Executor next-state: one word per EXEC cycle, reads then wait out the pipeline
  always_comb begin
    state_n    = state_r;
    op_n       = op_r;
    addr_n     = addr_r;
    remain_n   = remain_r;
    drain_n    = drain_r;
    cmd_pop_s  = 1'b0;
    wr_issue_s = 1'b0;
    rd_issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!cmd_empty) begin
          cmd_pop_s = 1'b1;
          op_n      = cmd_op_s;
          addr_n    = cmd_addr_s;
          remain_n  = {1'b0, cmd_bl_s} + 7'd1;
          state_n   = EXEC;
        end else begin
          state_n = IDLE;
        end
      end
      EXEC: begin
        wr_issue_s = (op_r == OP_WR);
        rd_issue_s = (op_r == OP_RD);
        if ((op_r == OP_NOP) || (remain_r == 7'd1)) begin
          if (op_r == OP_RD) begin
            state_n = DRAIN;
            drain_n = LAT_W'(READ_LAT - 1);
          end else begin
            state_n = IDLE;
          end
        end else begin
          remain_n = remain_r - 7'd1;
          addr_n   = addr_r + MEM_AW'(1);
        end
      end
      DRAIN: begin
        if (drain_r == '0) begin
          state_n = IDLE;
        end else begin
          drain_n = drain_r - LAT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Executor registers
  always_ff @(posedge c3_clk0) begin
    if (!c3_sys_rst_n) begin
      state_r  <= IDLE;
      op_r     <= OP_NOP;
      addr_r   <= '0;
      remain_r <= '0;
      drain_r  <= '0;
    end else begin
      state_r  <= state_n;
      op_r     <= op_n;
      addr_r   <= addr_n;
      remain_r <= remain_n;
      drain_r  <= drain_n;
    end
  end

  // An empty write FIFO replays the last popped word rather than stalling the burst
  assign wr_word_s  = wr_empty ? last_data_r : wr_dout_s[63:0];
  assign wr_bmask_s = wr_empty ? last_mask_r : wr_head_mask_s;
  assign rd_push_s  = pipe_vld_r[READ_LAT-1];

  // Word memory and read-data pipeline; data stages are qualified by pipe_vld_r
  always_ff @(posedge c3_clk0) begin
    if (wr_issue_s && c3_sys_rst_n) begin
      for (int b = 0; b < 8; b++) begin
        if (!wr_bmask_s[b]) mem_r[addr_r][8*b +: 8] <= wr_word_s[8*b +: 8];
      end
    end
    pipe_data_r[0] <= mem_r[addr_r];
    for (int i = 1; i < READ_LAT; i++) pipe_data_r[i] <= pipe_data_r[i-1];
  end

  // Pipeline valids, status pulses, sticky errors and last-popped write word
  always_ff @(posedge c3_clk0) begin
    if (!c3_sys_rst_n) begin
      pipe_vld_r    <= '0;
      wr_underrun_r <= 1'b0;
      wr_error_r    <= 1'b0;
      rd_overflow_r <= 1'b0;
      rd_error_r    <= 1'b0;
      last_data_r   <= 64'h0;
      last_mask_r   <= 8'h00;
    end else begin
      pipe_vld_r[0] <= rd_issue_s;
      for (int i = 1; i < READ_LAT; i++) pipe_vld_r[i] <= pipe_vld_r[i-1];
      wr_underrun_r <= wr_issue_s && wr_empty;
      wr_error_r    <= wr_error_r || (wr_issue_s && wr_empty);
      rd_overflow_r <= rd_push_s && rd_full;
      rd_error_r    <= rd_error_r || (rd_push_s && rd_full);
      if (wr_issue_s && !wr_empty) begin
        last_data_r <= wr_dout_s[63:0];
        last_mask_r <= wr_head_mask_s;
      end
    end
  end

  assign calib_done  = calib_done_r;
  assign wr_underrun = wr_underrun_r;
  assign wr_error    = wr_error_r;
  assign rd_overflow = rd_overflow_r;
  assign rd_error    = rd_error_r;

endmodule

// File: tb/tb_mcb_port_responder.sv
// Directed self-checking bench for mcb_port_responder (default parameters).
// Outputs are sampled 1 time unit after each rising edge.
module tb_mcb_port_responder;
  import mcb_resp_pkg::*;

  logic        c3_clk0 = 1'b0;
  logic        c3_sys_rst_n;
  logic        calib_done;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_empty, cmd_full;
  logic        wr_en;
  logic [7:0]  wr_mask;
  logic [63:0] wr_data;
  logic        wr_full, wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun, wr_error;
  logic        rd_en;
  logic [63:0] rd_data;
  logic        rd_full, rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow, rd_error;

  int total = 0;
  int bad = 0;
  int underrun_pulses = 0;
  int overflow_pulses = 0;
  int u0;
  int o0;

  mcb_port_responder dut (
    .c3_clk0(c3_clk0), .c3_sys_rst_n(c3_sys_rst_n), .calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full), .wr_empty(wr_empty),
    .wr_count(wr_count), .wr_underrun(wr_underrun), .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error)
  );

  always #5 c3_clk0 = ~c3_clk0;

  always @(negedge c3_clk0) begin
    if (wr_underrun) underrun_pulses <= underrun_pulses + 1;
    if (rd_overflow) overflow_pulses <= overflow_pulses + 1;
  end

  task automatic tick();
    @(posedge c3_clk0);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [63:0] d, input logic [7:0] m);
    wr_data = d;
    wr_mask = m;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic push_cmd(input logic [2:0] ins, input logic [5:0] bl, input logic [29:0] a);
    cmd_instr     = ins;
    cmd_bl        = bl;
    cmd_byte_addr = a;
    cmd_en        = 1'b1;
    tick();
    cmd_en        = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [63:0] exp);
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    c3_sys_rst_n  = 1'b0;
    cmd_en        = 1'b0;
    cmd_instr     = 3'b000;
    cmd_bl        = 6'd0;
    cmd_byte_addr = 30'h0;
    wr_en         = 1'b0;
    wr_mask       = 8'h00;
    wr_data       = 64'h0;
    rd_en         = 1'b0;
    repeat (3) tick();

    // reset state
    check("reset_flags",
          {calib_done, cmd_empty, cmd_full, wr_empty, wr_full, rd_empty, rd_full,
           wr_underrun, wr_error, rd_overflow, rd_error},
          11'b0_1_0_1_0_1_0_0_0_0_0);
    check("reset_counts", {wr_count, rd_count}, 14'd0);
    check("reset_rd_data", rd_data, 64'h0);

    // calibration: inputs ignored, calib_done after exactly 16 edges
    c3_sys_rst_n = 1'b1;
    cmd_en       = 1'b1;
    wr_en        = 1'b1;
    wr_data      = 64'hDEAD_BEEF;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("calib_low", calib_done, 1'b0);
    end
    check("cmd_ignored_precal", cmd_empty, 1'b1);
    check("wr_ignored_precal", wr_empty, 1'b1);
    cmd_en = 1'b0;
    wr_en  = 1'b0;
    tick();
    check("calib_high", calib_done, 1'b1);

    // 4-word write at 0x40 then readback with latency check
    push_wr(64'h11, 8'h00);
    push_wr(64'h22, 8'h00);
    push_wr(64'h33, 8'h00);
    push_wr(64'h44, 8'h00);
    check("wr_count_4", wr_count, 7'd4);
    push_cmd(INSTR_WR, 6'd3, 30'h40);
    repeat (8) tick();
    check("wr_drained", {wr_empty, wr_count}, {1'b1, 7'd0});
    check("no_underrun", wr_error, 1'b0);
    push_cmd(INSTR_RD, 6'd3, 30'h40);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("rd_empty_latency", rd_empty, 1'b1);
    end
    tick();
    check("rd_empty_first_low", rd_empty, 1'b0);
    pop_check("rd_w0", 64'h11);
    pop_check("rd_w1", 64'h22);
    pop_check("rd_w2", 64'h33);
    pop_check("rd_w3", 64'h44);
    repeat (2) tick();
    check("rd_drained", {rd_empty, rd_count}, {1'b1, 7'd0});

    // underrun: bl=1 with one queued word, read queued right behind the write
    u0 = underrun_pulses;
    push_wr(64'hAAAA_0000_0000_0001, 8'h00);
    push_cmd(INSTR_WR, 6'd1, 30'h80);
    push_cmd(INSTR_RD, 6'd1, 30'h80);
    repeat (14) tick();
    check("underrun_pulses", underrun_pulses - u0, 64'd1);
    check("wr_error_sticky", wr_error, 1'b1);
    check("underrun_rd_count", rd_count, 7'd2);
    pop_check("underrun_w0", 64'hAAAA_0000_0000_0001);
    pop_check("underrun_w1", 64'hAAAA_0000_0000_0001);

    // address wrap: burst of 4 from index 1023
    push_wr(64'hC0DE_0000_0000_0000, 8'h00);
    push_wr(64'hC0DE_0000_0000_0001, 8'h00);
    push_wr(64'hC0DE_0000_0000_0002, 8'h00);
    push_wr(64'hC0DE_0000_0000_0003, 8'h00);
    push_cmd(INSTR_WR_AP, 6'd3, 30'h1FF8);
    repeat (8) tick();
    push_cmd(INSTR_RD_AP, 6'd3, 30'h1FF8);
    push_cmd(INSTR_RD, 6'd0, 30'h0);
    repeat (20) tick();
    check("wrap_rd_count", rd_count, 7'd5);
    pop_check("wrap_1023", 64'hC0DE_0000_0000_0000);
    pop_check("wrap_0", 64'hC0DE_0000_0000_0001);
    pop_check("wrap_1", 64'hC0DE_0000_0000_0002);
    pop_check("wrap_2", 64'hC0DE_0000_0000_0003);
    pop_check("wrap_idx0_direct", 64'hC0DE_0000_0000_0001);

    // byte mask over word 0
    push_wr(64'h0, 8'h00);
    push_cmd(INSTR_WR, 6'd0, 30'h0);
    push_wr(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    push_cmd(INSTR_WR, 6'd0, 30'h0);
    push_cmd(INSTR_RD, 6'd0, 30'h0);
    repeat (15) tick();
    check("mask_rd_count", rd_count, 7'd1);
`ifdef MCB_RESP_MASK_EN
    pop_check("mask_readback", 64'hFFFF_FFFF_0000_0000);
`else
    pop_check("mask_readback", 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // read FIFO overflow: 64 + 1 words without popping
    o0 = overflow_pulses;
    push_cmd(INSTR_RD, 6'd63, 30'h100);
    push_cmd(INSTR_RD, 6'd0, 30'h100);
    repeat (90) tick();
    check("ovf_rd_count", rd_count, 7'd64);
    check("ovf_rd_full", rd_full, 1'b1);
    check("ovf_pulses", overflow_pulses - o0, 64'd1);
    check("rd_error_sticky", rd_error, 1'b1);
    check("wr_error_still_set", wr_error, 1'b1);

    // reset flushes FIFOs and clears sticky errors
    c3_sys_rst_n = 1'b0;
    tick();
    c3_sys_rst_n = 1'b1;
    check("rst2_rd", {rd_empty, rd_full, rd_count}, {1'b1, 1'b0, 7'd0});
    check("rst2_errors", {wr_error, rd_error, calib_done}, 3'b000);
    check("rst2_rd_data", rd_data, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
